// File: rtl/clock_enable_generator.sv
`default_nettype none
// ============================================================================
// clock_enable_generator : 7 MHz / E-clock / colour-clock / CPU enables on clk28m
// Revision: 1.0
// ============================================================================
module clock_enable_generator #(
  parameter int E_DIV     = 10,
  parameter int CPU_DIV_W = 3
) (
  input  logic                 clk28m,
  input  logic                 rst_n,
  input  logic [CPU_DIV_W-1:0] cpu_div_sel,
  output logic                 clk7_en,
  output logic                 clk7n_en,
  output logic                 c1,
  output logic                 c3,
  output logic                 cck,
  output logic [E_DIV-1:0]     eclk,
  output logic                 cpu_en,
  output logic [CPU_DIV_W-1:0] cpu_div_cur,
  output logic                 cpu_div_ack
);

  localparam int                 EW     = (E_DIV > 2) ? $clog2(E_DIV) : 1;
  localparam logic [EW-1:0]      E_LAST = EW'(E_DIV - 1);

  if ((E_DIV < 2) || (E_DIV > 16) || ((E_DIV % 2) != 0)) begin : g_bad_e_div
    $error("clock_enable_generator: E_DIV must be even and within 2..16");
  end

  logic [1:0]           ph_q, ph_d;
  logic [EW-1:0]        e_cnt_q, e_cnt_d;
  logic [CPU_DIV_W-1:0] k_q, k_d;
  logic [CPU_DIV_W-1:0] cur_q, cur_d;
  logic                 ack_q, ack_d;
  logic                 clk7_q, clk7_d;
  logic                 clk7n_q, clk7n_d;
  logic                 c1_q, c1_d;
  logic                 c3_q, c3_d;
  logic                 cck_q, cck_d;
  logic [E_DIV-1:0]     eclk_q, eclk_d;
  logic                 cpu_en_q, cpu_en_d;
  logic                 k_last;
  logic                 do_switch;

  always_comb begin
    ph_d    = ph_q + 2'd1;
    e_cnt_d = e_cnt_q;
    if (ph_q == 2'd3) begin
      e_cnt_d = (e_cnt_q == E_LAST) ? '0 : e_cnt_q + 1'b1;
    end

    // k runs 0..cur, so the last count of a CPU period is simply k == cur.
    k_last    = (k_q == cur_q);
    do_switch = (ph_q == 2'd3) && k_last && (cpu_div_sel != cur_q);
    cur_d     = do_switch ? cpu_div_sel : cur_q;
    ack_d     = do_switch;
    k_d       = (do_switch || k_last) ? '0 : k_q + 1'b1;

    // Output flops hold the decode of the next state, so each output is
    // a clean flop that lines up with the state of the same cycle.
    clk7_d   = (ph_d == 2'd0);
    clk7n_d  = (ph_d == 2'd2);
    c1_d     = (ph_d == 2'd0) || (ph_d == 2'd1);
    c3_d     = (ph_d == 2'd1) || (ph_d == 2'd2);
    cck_d    = ~e_cnt_d[0];
    cpu_en_d = (k_d == '0);
    eclk_d   = '0;
    for (int i = 0; i < E_DIV; i++) begin
      eclk_d[i] = (e_cnt_d == EW'(i));
    end
  end

  always_ff @(posedge clk28m or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= 2'd3;
      e_cnt_q  <= E_LAST;
      k_q      <= '0;
      cur_q    <= '0;
      ack_q    <= 1'b0;
      clk7_q   <= 1'b0;
      clk7n_q  <= 1'b0;
      c1_q     <= 1'b0;
      c3_q     <= 1'b0;
      cck_q    <= 1'b0;
      eclk_q   <= '0;
      cpu_en_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      e_cnt_q  <= e_cnt_d;
      k_q      <= k_d;
      cur_q    <= cur_d;
      ack_q    <= ack_d;
      clk7_q   <= clk7_d;
      clk7n_q  <= clk7n_d;
      c1_q     <= c1_d;
      c3_q     <= c3_d;
      cck_q    <= cck_d;
      eclk_q   <= eclk_d;
      cpu_en_q <= cpu_en_d;
    end
  end

  assign clk7_en     = clk7_q;
  assign clk7n_en    = clk7n_q;
  assign c1          = c1_q;
  assign c3          = c3_q;
  assign cck         = cck_q;
  assign eclk        = eclk_q;
  assign cpu_en      = cpu_en_q;
  assign cpu_div_cur = cur_q;
  assign cpu_div_ack = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_enable_generator.sv
`default_nettype none
// ============================================================================
// tb_clock_enable_generator : table vectors, corner sequences and random sel
// Revision: 1.0
// ============================================================================
module tb_clock_enable_generator;

  localparam int E_DIV     = 10;
  localparam int CPU_DIV_W = 3;

  logic                 clk28m = 1'b0;
  logic                 rst_n  = 1'b0;
  logic [CPU_DIV_W-1:0] cpu_div_sel = '0;
  logic                 clk7_en, clk7n_en, c1, c3, cck, cpu_en, cpu_div_ack;
  logic [E_DIV-1:0]     eclk;
  logic [CPU_DIV_W-1:0] cpu_div_cur;

  clock_enable_generator #(.E_DIV(E_DIV), .CPU_DIV_W(CPU_DIV_W)) dut (
    .clk28m      (clk28m),
    .rst_n       (rst_n),
    .cpu_div_sel (cpu_div_sel),
    .clk7_en     (clk7_en),
    .clk7n_en    (clk7n_en),
    .c1          (c1),
    .c3          (c3),
    .cck         (cck),
    .eclk        (eclk),
    .cpu_en      (cpu_en),
    .cpu_div_cur (cpu_div_cur),
    .cpu_div_ack (cpu_div_ack)
  );

  always #18 clk28m = ~clk28m;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time since release, ratio in force and when it started.
  int t;
  int m_cur;
  int m_b;
  bit m_ack;
  int last_en_t;
  logic [19:0] obs;

  typedef struct packed {
    logic [2:0] sel;
    logic       clk7;
    logic       c1;
    logic       c3;
    logic       en;
    logic       ack;
    logic [2:0] cur;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (t=%0d): got %h required %h", name, t, got, exp);
    end
  endtask

  function automatic logic [19:0] outs_now();
    return {clk7_en, clk7n_en, c1, c3, cck, cpu_en, cpu_div_ack, cpu_div_cur, eclk};
  endfunction

  function automatic logic [19:0] model_expect();
    int ph, e, d, k;
    logic [E_DIV-1:0] ev;
    ph = t % 4;
    e  = (t / 4) % E_DIV;
    d  = m_cur + 1;
    k  = (t - m_b) % d;
    ev = '0;
    ev[e] = 1'b1;
    return {ph == 0, ph == 2, ph < 2, (ph == 1) || (ph == 2), (e % 2) == 0,
            k == 0, m_ack, 3'(m_cur), ev};
  endfunction

  task automatic model_reset();
    t = 0; m_cur = 0; m_b = 0; m_ack = 0; last_en_t = -100;
  endtask

  // One clk28m cycle: check cycle t, then drive sel for the rest of cycle t.
  task automatic step(input logic [2:0] sel_v);
    int ph, d, k;
    @(posedge clk28m);
    #1;
    obs = outs_now();
    check("outputs", 32'(obs), 32'(model_expect()));
    if (obs[14]) last_en_t = t;
    cpu_div_sel = sel_v;
    ph = t % 4;
    d  = m_cur + 1;
    k  = (t - m_b) % d;
    m_ack = 0;
    if ((ph == 3) && (k == d - 1) && (int'(sel_v) != m_cur)) begin
      m_cur = int'(sel_v);
      m_b   = t + 1;
      m_ack = 1;
    end
    t++;
  endtask

  task automatic apply_reset();
    @(posedge clk28m);
    #1;
    rst_n = 1'b0;
    cpu_div_sel = '0;
    #1;
    check("reset_async_outputs", 32'(outs_now()), 32'h0);
    @(posedge clk28m);
    @(posedge clk28m);
    #1;
    check("reset_hold_outputs", 32'(outs_now()), 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int cnt, ack_t, gap;
    logic [2:0] rs;
    for (int i = 0; i < 17; i++) begin
      tbl[i].sel  = (i < 5) ? 3'd0 : 3'd3;
      tbl[i].clk7 = (i % 4) == 0;
      tbl[i].c1   = (i % 4) < 2;
      tbl[i].c3   = ((i % 4) == 1) || ((i % 4) == 2);
      tbl[i].en   = (i < 9) || ((i % 4) == 0);
      tbl[i].ack  = (i == 8);
      tbl[i].cur  = (i < 8) ? 3'd0 : 3'd3;
    end
    model_reset();

    // Scenario 1+3: reset, then sel 0 -> 3 at cycle 5.
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].sel);
      check("table_vector", 32'({obs[19], obs[17], obs[16], obs[14], obs[13], obs[12:10]}),
            32'({tbl[i].clk7, tbl[i].c1, tbl[i].c3, tbl[i].en, tbl[i].ack, tbl[i].cur}));
    end

    // Scenario 2: 40 7 MHz periods at d=1, eclk[0] high exactly 4 cycles per 40.
    apply_reset();
    cnt = 0;
    for (int i = 0; i < 160; i++) begin
      step(3'd0);
      if (i < 40 && obs[0]) cnt++;
    end
    check("eclk0_high_cycles", 32'(cnt), 32'd4);

    // Scenario 4: d=3 then request d=8.
    apply_reset();
    for (int i = 0; i < 6; i++) step(3'd2);
    check("cur_is_2", 32'(cpu_div_cur), 32'd2);
    ack_t = -1;
    for (int i = 0; i < 12 && ack_t < 0; i++) begin
      step(3'd7);
      if (obs[13]) ack_t = t - 1;
    end
    check("switch_to_7_seen", 32'(ack_t >= 0), 32'd1);
    check("switch_boundary_cycle", 32'(ack_t), 32'd16);
    for (int i = 0; i < 9; i++) begin
      step(3'd7);
      if (i == 0) gap = t - 1;
    end
    check("gap_after_switch", 32'(last_en_t - ack_t), 32'd8);

    // Scenario 5: sel wanders to 5 and back to 7 before the boundary.
    for (int i = 0; i < 3; i++) step(3'd5);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(3'd7);
      if (obs[13]) cnt++;
    end
    check("no_ack_after_revert", 32'(cnt), 32'd0);
    check("cur_still_7", 32'(cpu_div_cur), 32'd7);

    // Scenario 6: reset pulse while a switch is pending.
    step(3'd3);
    #2;
    rst_n = 1'b0;
    cpu_div_sel = '0;
    #1;
    check("midswitch_reset_outputs", 32'(outs_now()), 32'h0);
    @(posedge clk28m);
    #1;
    check("midswitch_reset_hold", 32'(outs_now()), 32'h0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(3'd0);

    // Randomised sel changes against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rs = 3'($urandom_range(0, 7));
      else if (i == 0) rs = 3'd0;
      step(rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
